md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit beside the E stage of the 5-stage pipeline.
//  - Executes mult/multu/div/divu on E-stage forwarded operands.
//  - Owns the HI/LO registers, which it writes on completion or on mthi/mtlo.
//  - Exports busy so the hazard unit stalls D-stage md-class instructions.
//  - mfhi/mflo read hi/lo combinationally through the E-stage result mux.

---
 rtl/md_unit_if.sv | 12 +
 rtl/md_unit.sv | 67 ++++++
 tb/tb_md_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the E stage and md_unit
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output start, md_op, src_a, src_b, input busy, hi, lo);
  modport slave(input start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/multu/div/divu unit owning HI/LO (clk, async active-low reset, md bus; MD_MADD_EN adds madd on md_op 7)
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);
  localparam int CMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
`ifdef MD_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, da, db, uq, ur, q, r;
  logic [63:0] prod_s, prod_u, res;
  logic go, done, sgn;
  always_comb begin
    go = state == IDLE && md.start && (md.md_op inside {3'd1, 3'd2, 3'd3, 3'd4} || (MADD_EN && md.md_op == 3'd7));
    done = state == RUN && cnt == CW'(1);
    state_nx = go ? RUN : done ? IDLE : state;
    sgn = op_q == 3'd3;
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    da = sgn && a_q[31] ? -a_q : a_q;
    db = sgn && b_q[31] ? -b_q : b_q;
    uq = db == 32'd0 ? 32'd0 : da / db;
    ur = db == 32'd0 ? 32'd0 : da % db;
    q = sgn && (a_q[31] ^ b_q[31]) ? -uq : uq;
    r = sgn && a_q[31] ? -ur : ur;
    res = op_q == 3'd1 ? prod_s :
          op_q == 3'd2 ? prod_u :
          op_q == 3'd7 ? {hi_q, lo_q} + prod_s :
          b_q == 32'd0 ? {a_q, 32'hFFFF_FFFF} : {r, q};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= go ? CW'(md.md_op inside {3'd3, 3'd4} ? DIV_CYCLES : MULT_CYCLES) : state == RUN ? cnt - CW'(1) : cnt;
      if (go) begin
        op_q <= md.md_op;
        a_q <= md.src_a;
        b_q <= md.src_b;
      end
      if (done) {hi_q, lo_q} <= res;
      else if (state == IDLE && md.start && md.md_op == 3'd5) hi_q <= md.src_a;
      else if (state == IDLE && md.start && md.md_op == 3'd6) lo_q <= md.src_a;
    end
  end
  assign md.busy = state == RUN;
  assign md.hi = hi_q;
  assign md.lo = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit
module tb_md_unit;
  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  logic clk, reset, probe, pb, held;
  logic [31:0] hh, hl;
  int checks, errors, bcnt;
  exp_t sb[$];
  exp_t e;
  md_unit_if bus();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut(.clk(clk), .reset(reset), .md(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic push(string n, logic [31:0] eh, logic [31:0] el, int cyc);
    exp_t x;
    x.name = n;
    x.hi = eh;
    x.lo = el;
    x.cyc = cyc;
    sb.push_back(x);
  endtask
  task automatic pop(output bit ok);
    ok = sb.size() != 0;
    if (ok) e = sb.pop_front();
    else begin
      checks++;
      errors++;
      $display("FAIL unexpected_output got hi=%h lo=%h expected none", bus.hi, bus.lo);
    end
  endtask
  always @(negedge clk) begin
    bit ok;
    if (probe) begin
      pop(ok);
      if (ok) begin
        chk(e.name, {bus.hi, bus.lo}, {e.hi, e.lo});
        chk({e.name, "_busy"}, 64'(bus.busy), 64'd0);
      end
    end else if (reset) begin
      if (bus.busy) begin
        if (!pb) begin
          bcnt = 1;
          hh = bus.hi;
          hl = bus.lo;
          held = 1'b1;
        end else begin
          bcnt++;
          if ({bus.hi, bus.lo} !== {hh, hl}) held = 1'b0;
        end
      end else if (pb) begin
        pop(ok);
        if (ok) begin
          chk(e.name, {bus.hi, bus.lo}, {e.hi, e.lo});
          chk({e.name, "_cycles"}, 64'(bcnt), 64'(e.cyc));
          chk({e.name, "_hold"}, 64'(held), 64'd1);
        end
      end
    end
    pb = reset && bus.busy;
  end
  task automatic probe_now(string n, logic [31:0] eh, logic [31:0] el);
    push(n, eh, el, 0);
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
  endtask
  task automatic wait_idle(string n);
    int i = 0;
    while (bus.busy && i < 200) begin
      @(posedge clk);
      #1 i++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got busy=1 expected busy=0 within 200 cycles", n);
    end
    @(negedge clk);
    #1;
  endtask
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic run_op(string n, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] eh, logic [31:0] el, int cyc);
    push(n, eh, el, cyc);
    issue(op, a, b);
    wait_idle(n);
  endtask
  task automatic imm_op(string n, logic [2:0] op, logic [31:0] a, logic [31:0] eh, logic [31:0] el);
    issue(op, a, 32'd0);
    probe_now(n, eh, el);
  endtask
  initial begin
    reset = 1'b0;
    probe = 1'b0;
    pb = 1'b0;
    held = 1'b0;
    checks = 0;
    errors = 0;
    bcnt = 0;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    probe_now("reset", 32'd0, 32'd0);
    run_op("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op("multu_neg2x3", 3'd2, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFA, 5);
    run_op("mult_m1xm1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 5);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 5);
    run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
    run_op("divu_7_0", 3'd4, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10);
    run_op("div_m5_0", 3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    run_op("divu_100_7", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.md_op = 3'd5;
    bus.src_a = 32'h1234_5678;
    @(posedge clk);
    #1 bus.md_op = 3'd6;
    bus.src_a = 32'd9;
    probe_now("mthi", 32'h1234_5678, 32'd14);
    @(posedge clk);
    #1 bus.start = 1'b0;
    probe_now("mtlo", 32'h1234_5678, 32'd9);
    imm_op("nop_op0", 3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 32'd9);
    @(posedge clk);
    #1 bus.md_op = 3'd1;
    bus.src_a = 32'd3;
    bus.src_b = 32'd3;
    @(posedge clk);
    #1 probe_now("start_low", 32'h1234_5678, 32'd9);
    imm_op("mthi_0", 3'd5, 32'd0, 32'd0, 32'd9);
    imm_op("mtlo_ones", 3'd6, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run_op("madd_1x1", 3'd7, 32'd1, 32'd1, 32'd1, 32'd0, 5);
`else
    imm_op("op7_nop", 3'd7, 32'd1, 32'd0, 32'hFFFF_FFFF);
`endif
    push("start_while_busy", 32'd0, 32'd35, 5);
    issue(3'd1, 32'd5, 32'd7);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.md_op = 3'd1;
    bus.src_a = 32'd100;
    bus.src_b = 32'd100;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle("start_while_busy");
    issue(3'd1, 32'd3, 32'd4);
    @(posedge clk);
    #1 reset = 1'b0;
    probe_now("reset_mid_run", 32'd0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_op("multu_after_reset", 3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
